dds_reader: RTL and testbench
=============================

DDS_READER -- requirements
Module: dds_reader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 9, giving the waveform table address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the sample width.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 24, giving the phase accumulator width; ACC_WIDTH >= ADDR_WIDTH.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  level; high = synthesize, low = stop.
REQ-007 tune_valid  in  1  new tuning word offered.
REQ-008 tune_word  in  ACC_WIDTH  phase increment offered with tune_valid.
REQ-009 tune_ready  out  1  tuning word accepted on an edge where tune_valid && tune_ready.
REQ-010 phase_clr  in  1  synchronous accumulator clear pulse.
REQ-011 rd_addr  out  ADDR_WIDTH  waveform table read address, equal to acc[ACC_WIDTH-1 -: ADDR_WIDTH].
REQ-012 rd_data  in  DATA_WIDTH  table data, registered by the table one clock after rd_addr is sampled.
REQ-013 sample  out  DATA_WIDTH  registered output sample.
REQ-014 sample_valid  out  1  one-cycle qualifier per sample.
REQ-015 sample_wrap  out  1  high with the sample whose accumulation overflowed.
REQ-016 busy  out  1  high whenever state != IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE after 2 cycles; DRAIN->RUN immediately if enable=1.
REQ-018 In RUN with enable=1 each edge SHALL perform acc <= (acc + tw) mod 2^ACC_WIDTH and launch one pipeline token (v1 <= 1, w1 <= adder carry-out).
REQ-019 In IDLE and DRAIN acc SHALL hold and no token SHALL be launched; in IDLE->RUN transition edge the first accumulation SHALL occur.
REQ-020 Pipeline SHALL be: edge E0 accumulate (v1,w1); edge E1 table registers rd_data, v2<=v1, w2<=w1; edge E2 sample<=rd_data, sample_valid<=v2, sample_wrap<=w2 — fixed latency 2 clocks from accumulate edge to sample visible.
REQ-021 sample SHALL update only when v2=1; otherwise hold its previous value.
REQ-022 tune_ready SHALL be 1 in IDLE and RUN, 0 in DRAIN.
REQ-023 An accepted tune_word SHALL load tw on the accept edge and first be used in the accumulation on the following edge; the accept-edge accumulation uses the old tw.
REQ-024 phase_clr=1 SHALL set acc to 0 on that edge, overriding accumulation; a token is still launched if in RUN with enable=1, with wrap=0.
REQ-025 Simultaneous phase_clr and tune accept SHALL both take effect on the same edge.
REQ-026 tw = 0 SHALL hold the address constant while still producing one valid sample per RUN cycle.
REQ-027 Tokens in flight SHALL complete during DRAIN; exactly as many samples emerge as accumulations performed.

Reset
REQ-028 rst high SHALL asynchronously force: state=IDLE, acc=0, tw=0, v1=v2=w1=w2=0, sample=0, sample_valid=0, sample_wrap=0, busy=0, tune_ready=1 (rd_addr thereby 0).
REQ-029 Reset mid-RUN SHALL discard in-flight tokens; no sample_valid after rst deasserts until new accumulations.

Verification (table preloaded mem[i] = i mod 256, defaults)
REQ-030 Ramp: load tw=0x008000, enable=1 -> sample_valid continuous from 2nd edge after enable edge, samples 1,2,3,... .
REQ-031 Wrap: same as REQ-030 for 512 cycles -> sample 0 with sample_wrap=1 exactly once per 512 samples.
REQ-032 Retune: tw=0x008000 running, accept tw=0x010000 -> sample sequence steps by 1 once more, then by 2.
REQ-033 Stop: drop enable after N accumulations -> exactly N samples, busy falls 2 cycles after RUN->DRAIN, tune_ready=0 during DRAIN.
REQ-034 Clear/zero: phase_clr mid-ramp -> next sample 0, wrap=0; tw=0 -> constant sample 0 valid every cycle.
REQ-035 Async reset mid-ramp -> outputs 0 immediately without clock edge, no residual sample_valid.

Source files
------------

// File: rtl/dds_reader.sv
// dds_reader: phase-accumulator DDS front end. Steps a phase accumulator by a
// tuning word, addresses an external registered waveform table with the
// accumulator's top bits, and re-registers the returned data as samples.
//
// Handshake: tune_word is transferred on a rising edge where
// tune_valid && tune_ready. tune_valid may be held or dropped freely;
// tune_ready depends only on the FSM state and never on tune_valid.
module dds_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  tune_valid,
  input  logic [ACC_WIDTH-1:0]  tune_word,
  output logic                  tune_ready,
  input  logic                  phase_clr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  sample_wrap,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state;
  logic                 drain_cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] tw;
  logic [ACC_WIDTH:0]   sum;
  logic                 launch;
  logic                 tune_accept;
  logic                 v1, w1, v2, w2;

  // Any edge with enable high either stays in or enters RUN, and that edge
  // accumulates; with enable low the accumulator holds.
  assign launch      = enable;
  assign tune_ready  = (state != DRAIN);
  assign tune_accept = tune_valid && tune_ready;
  assign busy        = (state != IDLE);
  assign fsm_state   = state;
  assign rd_addr     = acc[ACC_WIDTH-1 -: ADDR_WIDTH];

  // Extra top bit of the sum is the accumulator carry-out (wrap flag).
  always_comb begin
    sum = {1'b0, acc} + {1'b0, tw};
  end

  // Control FSM: DRAIN lasts two cycles so in-flight tokens leave the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (drain_cnt) begin
            state <= IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Phase accumulator and tuning word; a clear wins over accumulation while
  // a tune accept on the same edge still loads the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      tw  <= '0;
    end else begin
      if (tune_accept) tw <= tune_word;
      if (phase_clr) begin
        acc <= '0;
      end else if (launch) begin
        acc <= sum[ACC_WIDTH-1:0];
      end
    end
  end

  // Token pipeline: launch, table read stage, output sample register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1           <= 1'b0;
      w1           <= 1'b0;
      v2           <= 1'b0;
      w2           <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_wrap  <= 1'b0;
    end else begin
      v1           <= launch;
      w1           <= launch && !phase_clr && sum[ACC_WIDTH];
      v2           <= v1;
      w2           <= w1;
      sample_valid <= v2;
      sample_wrap  <= w2;
      if (v2) sample <= rd_data;
    end
  end

endmodule

// File: tb/tb_dds_reader.sv
// tb_dds_reader: directed bench for dds_reader with a registered 512x8 ramp
// table (mem[i] = i mod 256) modelled next to the DUT.
module tb_dds_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tune_valid;
  logic [23:0] tune_word;
  logic        tune_ready;
  logic        phase_clr;
  logic [8:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        sample_wrap;
  logic        busy;
  logic [1:0]  fsm_state;

  logic [7:0]  mem [512];

  int n_pass  = 0;
  int n_total = 0;

  dds_reader dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .tune_valid   (tune_valid),
    .tune_word    (tune_word),
    .tune_ready   (tune_ready),
    .phase_clr    (phase_clr),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_wrap  (sample_wrap),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Waveform table, one-cycle registered read
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i % 256);
  end
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    int wrap_cnt;
    int wrap_k;
    int valid_cnt;

    rst        = 1'b1;
    enable     = 1'b0;
    tune_valid = 1'b0;
    tune_word  = '0;
    phase_clr  = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_wrap", sample_wrap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tune_ready, 1);
    chk("rst_addr", rd_addr, 0);
    chk("rst_state", fsm_state, 0);
    rst = 1'b0;

    // Load tw = 0x008000 while idle
    tune_valid = 1'b1;
    tune_word  = 24'h008000;
    @(negedge clk);
    tune_valid = 1'b0;
    chk("idle_addr_hold", rd_addr, 0);
    chk("idle_busy", busy, 0);

    // Ramp and wrap: after edge k, rd_addr = (k+1) mod 512; from k=2 the
    // sample is (k-1) mod 512 mod 256 with wrap only at k-1 = 512.
    enable   = 1'b1;
    wrap_cnt = 0;
    wrap_k   = -1;
    for (int k = 0; k <= 520; k++) begin
      @(negedge clk);
      chk("ramp_addr", rd_addr, 32'((k + 1) % 512));
      if (k < 2) begin
        chk("ramp_lat_valid", sample_valid, 0);
      end else begin
        chk("ramp_valid", sample_valid, 1);
        chk("ramp_sample", sample, 32'(((k - 1) % 512) % 256));
        chk("ramp_wrap", sample_wrap, (((k - 1) % 512) == 0) ? 1 : 0);
        if (sample_wrap) begin
          wrap_cnt++;
          wrap_k = k;
        end
      end
      if (k == 0) chk("ramp_busy", busy, 1);
    end
    chk("wrap_count", wrap_cnt, 1);
    chk("wrap_pos", wrap_k, 513);

    // Retune to 0x010000: accept edge still uses the old word
    tune_valid = 1'b1;
    tune_word  = 24'h010000;
    @(negedge clk);
    tune_valid = 1'b0;
    chk("retune_addr0", rd_addr, 10);
    chk("retune_s0", sample, 8);
    @(negedge clk);
    chk("retune_addr1", rd_addr, 12);
    chk("retune_s1", sample, 9);
    @(negedge clk);
    chk("retune_addr2", rd_addr, 14);
    chk("retune_s2", sample, 10);
    @(negedge clk);
    chk("retune_addr3", rd_addr, 16);
    chk("retune_s3", sample, 12);

    // Clear together with a retune back to 0x008000
    phase_clr  = 1'b1;
    tune_valid = 1'b1;
    tune_word  = 24'h008000;
    @(negedge clk);
    phase_clr  = 1'b0;
    tune_valid = 1'b0;
    chk("clr_addr", rd_addr, 0);
    chk("clr_s_prev", sample, 14);
    @(negedge clk);
    chk("clr_addr_next", rd_addr, 1);
    chk("clr_s_prev2", sample, 16);
    @(negedge clk);
    chk("clr_addr_next2", rd_addr, 2);
    chk("clr_sample", sample, 0);
    chk("clr_valid", sample_valid, 1);
    chk("clr_wrap", sample_wrap, 0);

    // Stop: two tokens still in flight drain out, then idle
    enable = 1'b0;
    @(negedge clk);
    chk("drain0_state", fsm_state, 2);
    chk("drain0_busy", busy, 1);
    chk("drain0_ready", tune_ready, 0);
    chk("drain0_addr", rd_addr, 2);
    chk("drain0_valid", sample_valid, 1);
    chk("drain0_sample", sample, 1);
    @(negedge clk);
    chk("drain1_busy", busy, 1);
    chk("drain1_ready", tune_ready, 0);
    chk("drain1_valid", sample_valid, 1);
    chk("drain1_sample", sample, 2);
    @(negedge clk);
    chk("idle_busy_fall", busy, 0);
    chk("idle_ready", tune_ready, 1);
    chk("idle_valid", sample_valid, 0);
    chk("idle_sample_hold", sample, 2);

    // tw = 0 plus clear in idle, then 5 accumulations -> 5 samples of 0
    tune_valid = 1'b1;
    tune_word  = '0;
    phase_clr  = 1'b1;
    @(negedge clk);
    tune_valid = 1'b0;
    phase_clr  = 1'b0;
    chk("zero_addr", rd_addr, 0);
    valid_cnt = 0;
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 4) enable = 1'b0;
      chk("zero_addr_hold", rd_addr, 0);
      if (sample_valid) begin
        valid_cnt++;
        chk("zero_sample", sample, 0);
      end
    end
    chk("zero_count", valid_cnt, 5);
    chk("zero_end_busy", busy, 0);

    // Async reset mid-ramp
    tune_valid = 1'b1;
    tune_word  = 24'h008000;
    @(negedge clk);
    tune_valid = 1'b0;
    enable = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_sample", sample, 4);
    chk("pre_rst_addr", rd_addr, 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_sample", sample, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", rd_addr, 0);
    chk("arst_ready", tune_ready, 1);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", sample_valid, 0);
    end
    // tw was cleared by reset: running again keeps address 0
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_addr", rd_addr, 0);
    chk("post_rst_new_valid", sample_valid, 1);
    chk("post_rst_new_sample", sample, 0);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
